axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the AXI-lite read channels (AR/R).
- Shares one memory read port between instruction fetch (master 0, IFU) and load/store (master 1, LSU).
- Sits between the core's fetch/mem stages and the memory/SRAM model.
- One outstanding read at a time; round-robin fairness. LSU write channels bypass this block.

Parameters:
- ADDR_WIDTH, 32, read address width.
- DATA_WIDTH, 64, read data width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- m0_araddr  input  ADDR_WIDTH  IFU read address.
- m0_arvalid  input  1  IFU address valid.
- m0_arready  output  1  IFU address accepted.
- m0_rdata  output  DATA_WIDTH  IFU read data.
- m0_rresp  output  2  IFU read response.
- m0_rvalid  output  1  IFU data valid.
- m0_rready  input  1  IFU data accept.
- m1_araddr  input  ADDR_WIDTH  LSU read address.
- m1_arvalid  input  1  LSU address valid.
- m1_arready  output  1  LSU address accepted.
- m1_rdata  output  DATA_WIDTH  LSU read data.
- m1_rresp  output  2  LSU read response.
- m1_rvalid  output  1  LSU data valid.
- m1_rready  input  1  LSU data accept.
- s_araddr  output  ADDR_WIDTH  slave read address.
- s_arvalid  output  1  slave address valid.
- s_arready  input  1  slave address accepted.
- s_rdata  input  DATA_WIDTH  slave read data.
- s_rresp  input  2  slave read response.
- s_rvalid  input  1  slave data valid.
- s_rready  output  1  slave data accept.

Behaviour:
- State register with states ARB_IDLE, ARB_AR and ARB_R. Also holds registered grant (0/1) and last_grant.
- Reset (rst=0 at posedge):
  - state=ARB_IDLE, last_grant=0, so LSU wins the first tie.
  - All outputs low while in ARB_IDLE: s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0.
  - Reset mid-transaction aborts unconditionally. The slave is reset by the same rst.
- ARB_IDLE:
  - If any m*_arvalid=1, latch grant:
    - only one requester: that master;
    - both requesting: the master != last_grant.
  - Then go to ARB_AR. No request: stay.
  - Arbitration costs exactly 1 cycle: s_arvalid rises the cycle after m*_arvalid is first seen in IDLE.
- ARB_AR:
  - s_araddr = granted master's araddr; s_arvalid = granted master's arvalid.
  - Granted m*_arready = s_arready; the other master's arready = 0.
  - On s_arvalid&s_arready go to ARB_R.
  - Granted master dropping arvalid before handshake is a protocol violation. Grant is held regardless; no deassert-driven transition.
- ARB_R:
  - Granted m*_rdata/m*_rresp = s_rdata/s_rresp.
  - Granted m*_rvalid = s_rvalid; s_rready = granted m*_rready. Non-granted rvalid = 0.
  - On s_rvalid&s_rready: last_grant<=grant, go to ARB_IDLE.
- Data and address broadcast:
  - m*_rdata/m*_rresp may be driven with s_rdata/s_rresp to both masters at all times. Only rvalid is gated.
  - s_araddr outside ARB_AR is don't-care, but is driven from m0 to avoid X.
- rresp passthrough: SLVERR/DECERR are forwarded unmodified; the arbiter takes no action.
- Throughput: one read per minimum 3 cycles (IDLE, AR, R). Back-to-back same-master requests are still subject to round-robin against a pending other master.
- A new request arriving during ARB_AR/ARB_R waits; its arready stays 0 until granted.

Decomposition:
- Shared package (arb_defs) holds:
  - state encodings ARB_IDLE=2'd0, ARB_AR=2'd1, ARB_R=2'd2;
  - master IDs MST_IFU=1'b0, MST_LSU=1'b1;
  - AXI resp constants OKAY=2'b00, SLVERR=2'b10.
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin selector (req[1:0], last_grant -> grant, any). Reused later for the write-channel arbiter.
- The grant/state registers stay in axi_rd_arbiter, using the existing Reg primitive style.

Test Plan:
- Reset then single IFU read: m0_araddr=0x80000000 asserted at cycle 0 -> s_arvalid=1 with s_araddr=0x80000000 at cycle 1. Slave returns 0xDEADBEEF_00000013 -> m0_rvalid=1 with that data, and m1_rvalid stays 0.
- Simultaneous first requests: m0 at 0x80000000, m1 at 0x80001000 in the same cycle -> LSU served first (s_araddr=0x80001000), then IFU. last_grant ends at 0.
- Sustained contention: both arvalid held for 6 transactions -> grant order is LSU, IFU, LSU, IFU, LSU, IFU. No master is served twice in a row.
- Slave backpressure: s_arready low for 4 cycles, s_rvalid delayed 5 cycles, m1_rready low 2 cycles after rvalid -> s_araddr and grant stay stable throughout. The transaction completes exactly on the s_rvalid&s_rready cycle, with no duplicate handshake.
- Error response: slave returns rresp=2'b10 for an LSU read -> m1_rresp=2'b10 and m1_rvalid=1. The next IFU request is granted normally.
- Reset mid-op: rst=0 while in ARB_R with s_rvalid=0 -> next cycle state=ARB_IDLE and all valids/readies are 0. After release, the first tie goes to LSU.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// arb_defs: shared definitions for the AXI-lite read/write arbiters
// Provides the arbiter state encoding, master IDs and AXI response codes.
package arb_defs;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_t;
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin selector
// Ports: i_req[1:0] request vector, i_last previous winner,
//        o_grant chosen master, o_any at least one request present.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_any
);
  // On a tie the master that did not win last time is chosen.
  assign o_grant = &i_req ? ~i_last : i_req[1];
  assign o_any   = |i_req;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master (IFU=0, LSU=1) to one-slave AXI-lite read arbiter
// Ports: clk, rst (sync, active-low); m0_*/m1_* master AR/R channels;
//        s_* slave AR/R channels. One outstanding read, round-robin grant.
module axi_rd_arbiter
  import arb_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready
);
  arb_state_t r_state, w_next;
  logic r_grant, r_last, w_pick, w_any, w_ar, w_r, w_lsu;
  rr_pick2 u_pick (
    .i_req   ({m1_arvalid, m0_arvalid}),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );
  assign w_ar  = r_state == ARB_AR;
  assign w_r   = r_state == ARB_R;
  assign w_lsu = r_grant == MST_LSU;
  // Address mux defaults to m0 outside the AR phase so the bus never floats to X.
  assign s_araddr   = w_ar && w_lsu ? m1_araddr : m0_araddr;
  assign s_arvalid  = w_ar && (w_lsu ? m1_arvalid : m0_arvalid);
  assign m0_arready = w_ar && !w_lsu && s_arready;
  assign m1_arready = w_ar && w_lsu && s_arready;
  assign s_rready   = w_r && (w_lsu ? m1_rready : m0_rready);
  assign m0_rvalid  = w_r && !w_lsu && s_rvalid;
  assign m1_rvalid  = w_r && w_lsu && s_rvalid;
  // Read data and response go to both masters; only rvalid selects the owner.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  always_comb begin
    w_next = ARB_IDLE;
    w_next = r_state == ARB_IDLE ? (w_any ? ARB_AR : ARB_IDLE) :
             w_ar ? (s_arvalid && s_arready ? ARB_R : ARB_AR) :
             w_r  ? (s_rvalid && s_rready ? ARB_IDLE : ARB_R) : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_grant <= MST_IFU;
      r_last  <= MST_IFU;
    end else begin
      r_state <= w_next;
      if (r_state == ARB_IDLE && w_any) r_grant <= w_pick;
      if (w_r && s_rvalid && s_rready) r_last <= r_grant;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized + directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [31:0] m_araddr[2];
  logic        m_arvalid[2], m_arready[2], m_rvalid[2], m_rready[2];
  logic [63:0] m_rdata[2];
  logic [1:0]  m_rresp[2];
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;

  axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit rst_req, req_en[2], fix_en[2];
  logic [31:0] fix_addr[2];
  int p_req, p_ar, p_rr, r_delay, resp_mode, ar_hold, rr_hold[2];
  bit sl_busy;
  logic [31:0] sl_addr;
  logic [1:0] sl_resp;
  int rd_wait;
  logic [31:0] q_addr[2][$];
  logic [31:0] ar_log[$];
  logic [63:0] rx_data[2][$];
  logic [1:0]  rx_resp[2][$];
  int grants[$], done_cyc[$], req_cyc[2], first_sarv;
  // Reference model: which master owns the slave (-1 none), whether its
  // address has been accepted, and who was served last.
  int own = -1, last = 0;
  bit ph = 0, known = 0;

  function automatic logic [63:0] data_of(logic [31:0] a);
    return {a ^ 32'h5EADBEEF, a ^ 32'h80000013};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    int o;
    bit e_arv, e_rrdy, e_arr[2], e_rv[2], hs_mar[2], hs_mr[2], hs_ar, hs_r;
    @(negedge clk);
    rst = rst_req;
    for (int i = 0; i < 2; i++)
      if (req_en[i] && !m_arvalid[i] && $urandom_range(99) < p_req) begin
        m_arvalid[i] = 1'b1;
        m_araddr[i]  = fix_en[i] ? fix_addr[i] : ($urandom & ~32'h7);
        req_cyc[i]   = cyc;
      end
    s_arready = !sl_busy && ar_hold == 0 && $urandom_range(99) < p_ar;
    s_rvalid  = sl_busy && rd_wait == 0;
    s_rdata   = s_rvalid ? data_of(sl_addr) : {$urandom, $urandom};
    s_rresp   = s_rvalid ? sl_resp : 2'($urandom);
    #1;
    for (int i = 0; i < 2; i++) m_rready[i] = rr_hold[i] == 0 && $urandom_range(99) < p_rr;
    #1;
    o = own < 0 ? 0 : own;
    e_arv  = own >= 0 && !ph && m_arvalid[o];
    e_rrdy = own >= 0 && ph && m_rready[o];
    for (int i = 0; i < 2; i++) begin
      e_arr[i] = own == i && !ph && s_arready;
      e_rv[i]  = own == i && ph && s_rvalid;
    end
    if (known) begin
      chk("s_arvalid", s_arvalid, e_arv);
      chk("s_rready", s_rready, e_rrdy);
      if (e_arv) chk("s_araddr", s_araddr, m_araddr[o]);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_arready", i), m_arready[i], e_arr[i]);
        chk($sformatf("m%0d_rvalid", i), m_rvalid[i], e_rv[i]);
        if (e_rv[i]) begin
          chk($sformatf("m%0d_rdata", i), m_rdata[i], s_rdata);
          chk($sformatf("m%0d_rresp", i), m_rresp[i], s_rresp);
        end
      end
    end
    if (first_sarv < 0 && s_arvalid) first_sarv = cyc;
    hs_ar = s_arvalid && s_arready;
    hs_r  = s_rvalid && s_rready;
    for (int i = 0; i < 2; i++) begin
      hs_mar[i] = m_arvalid[i] && m_arready[i];
      hs_mr[i]  = m_rvalid[i] && m_rready[i];
    end
    if (!rst) begin
      own = -1; ph = 0; last = 0; known = 1; sl_busy = 0;
      for (int i = 0; i < 2; i++) q_addr[i].delete();
    end else begin
      if (own < 0) begin
        if (m_arvalid[0] || m_arvalid[1]) begin
          own = (m_arvalid[0] && m_arvalid[1]) ? 1 - last : (m_arvalid[1] ? 1 : 0);
          ph = 0;
          grants.push_back(own);
        end
      end else if (!ph) begin
        if (e_arv && s_arready) ph = 1;
      end else if (s_rvalid && m_rready[o]) begin
        last = own;
        own = -1;
      end
      if (!sl_busy && hs_ar) begin
        sl_busy = 1; sl_addr = s_araddr; ar_log.push_back(s_araddr);
        rd_wait = r_delay < 0 ? $urandom_range(3) : r_delay;
        sl_resp = resp_mode < 0 ? 2'($urandom) : 2'(resp_mode);
      end else if (sl_busy && hs_r) begin
        sl_busy = 0; done_cyc.push_back(cyc);
      end else if (sl_busy && rd_wait > 0) rd_wait--;
      if (s_arvalid && ar_hold > 0) ar_hold--;
      for (int i = 0; i < 2; i++) begin
        if (m_rvalid[i] && rr_hold[i] > 0) rr_hold[i]--;
        if (hs_mr[i]) begin
          rx_data[i].push_back(m_rdata[i]);
          rx_resp[i].push_back(m_rresp[i]);
          if (q_addr[i].size() == 0) chk($sformatf("m%0d_unexpected_rvalid", i), 1, 0);
          else chk($sformatf("m%0d_txn_data", i), m_rdata[i], data_of(q_addr[i].pop_front()));
        end
        if (hs_mar[i]) q_addr[i].push_back(m_araddr[i]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) if (!rst || hs_mar[i]) m_arvalid[i] = 1'b0;
  endtask

  task automatic clear_logs();
    ar_log.delete(); grants.delete(); done_cyc.delete();
    for (int i = 0; i < 2; i++) begin rx_data[i].delete(); rx_resp[i].delete(); end
    first_sarv = -1;
  endtask

  task automatic do_reset();
    rst_req = 0;
    step();
    step();
    rst_req = 1;
    clear_logs();
  endtask

  task automatic idle_zero(string tag);
    chk({tag, "_s_arvalid"}, s_arvalid, 0);
    chk({tag, "_s_rready"}, s_rready, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_m%0d_arready", tag, i), m_arready[i], 0);
      chk($sformatf("%s_m%0d_rvalid", tag, i), m_rvalid[i], 0);
    end
  endtask

  task automatic issue(bit m0, bit m1);
    req_en[0] = m0; req_en[1] = m1;
    step();
    req_en[0] = 0; req_en[1] = 0;
  endtask

  initial begin
    rst = 1'b0; rst_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0; m_arvalid[i] = 0; m_rready[i] = 0; req_en[i] = 0;
      fix_en[i] = 1; rr_hold[i] = 0; req_cyc[i] = 0;
    end
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    sl_busy = 0; sl_addr = '0; sl_resp = '0; rd_wait = 0;
    p_req = 100; p_ar = 100; p_rr = 100; r_delay = 0; resp_mode = 0; ar_hold = 0;
    fix_addr[0] = 32'h8000_0000; fix_addr[1] = 32'h8000_1000;
    first_sarv = -1;

    do_reset();
    idle_zero("reset");

    issue(1, 0);
    for (int k = 0; k < 50 && rx_data[0].size() < 1; k++) step();
    chk("t1_done", rx_data[0].size(), 1);
    chk("t1_ar_latency", first_sarv - req_cyc[0], 1);
    chk("t1_s_araddr", ar_log[0], 32'h8000_0000);
    chk("t1_rdata", rx_data[0][0], 64'hDEADBEEF_00000013);
    chk("t1_m1_silent", rx_data[1].size(), 0);

    do_reset();
    issue(1, 1);
    for (int k = 0; k < 50 && rx_data[0].size() < 1; k++) step();
    issue(1, 1);
    for (int k = 0; k < 50 && done_cyc.size() < 3; k++) step();
    chk("t2_done", done_cyc.size(), 3);
    chk("t2_first_lsu", ar_log[0], 32'h8000_1000);
    chk("t2_then_ifu", ar_log[1], 32'h8000_0000);
    chk("t2_next_tie_lsu", ar_log[2], 32'h8000_1000);
    chk("t2_model_grant0", grants[0], 1);

    do_reset();
    req_en[0] = 1; req_en[1] = 1;
    for (int k = 0; k < 100 && done_cyc.size() < 6; k++) step();
    req_en[0] = 0; req_en[1] = 0;
    chk("t3_done", done_cyc.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_order%0d", k), ar_log[k], k % 2 == 0 ? 32'h8000_1000 : 32'h8000_0000);
    for (int k = 0; k < 20; k++) step();

    do_reset();
    ar_hold = 4; r_delay = 5; rr_hold[1] = 2;
    issue(0, 1);
    for (int k = 0; k < 40 && done_cyc.size() < 1; k++) step();
    for (int k = 0; k < 5; k++) step();
    chk("t4_done_once", done_cyc.size(), 1);
    chk("t4_latency", done_cyc[0] - req_cyc[1], 13);
    chk("t4_one_ar", ar_log.size(), 1);
    chk("t4_rx", rx_data[1].size(), 1);
    r_delay = 0;

    do_reset();
    resp_mode = 2;
    issue(0, 1);
    for (int k = 0; k < 30 && rx_resp[1].size() < 1; k++) step();
    resp_mode = 0;
    chk("t5_slverr", rx_resp[1].size() == 1 && rx_resp[1][0] == 2'b10, 1);
    issue(1, 0);
    for (int k = 0; k < 30 && rx_resp[0].size() < 1; k++) step();
    chk("t5_ifu_after", rx_resp[0].size() == 1 && rx_resp[0][0] == 2'b00, 1);
    chk("t5_ifu_addr", ar_log[1], 32'h8000_0000);

    do_reset();
    r_delay = 20;
    issue(0, 1);
    for (int k = 0; k < 20 && !(own >= 0 && ph); k++) step();
    chk("t6_in_r", own == 1 && ph, 1);
    rst_req = 0;
    step();
    idle_zero("t6_after_rst");
    rst_req = 1; r_delay = 0;
    clear_logs();
    issue(1, 1);
    for (int k = 0; k < 30 && done_cyc.size() < 1; k++) step();
    chk("t6_tie_lsu", ar_log.size() > 0 && ar_log[0] == 32'h8000_1000, 1);
    for (int k = 0; k < 30 && done_cyc.size() < 2; k++) step();

    fix_en[0] = 0; fix_en[1] = 0;
    p_req = 30; p_ar = 60; p_rr = 60; r_delay = -1; resp_mode = -1;
    req_en[0] = 1; req_en[1] = 1;
    for (int k = 0; k < 3000; k++) begin
      rst_req = $urandom_range(599) != 0;
      if ($urandom_range(49) == 0) ar_hold = $urandom_range(4);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
